// File: rtl/button_bounce_gen.sv
// button_bounce_gen: drives a raw, bouncing push-button waveform (press bounce, hold, release bounce).
// Define BOUNCE_GEN_NOISE_EN to take bounce bits from a 16-bit LFSR instead of a plain toggle.
module button_bounce_gen #(
    parameter int unsigned DIV          = 500_000,
    parameter int unsigned BOUNCE_TICKS = 4,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press,
    input  logic [7:0] hold_ticks,
    output logic       button,
    output logic       busy,
    output logic       done
);

    localparam int unsigned    CW          = $clog2(DIV);
    localparam int unsigned    BW          = $clog2(BOUNCE_TICKS + 1);
    localparam logic [CW-1:0]  DIV_LAST    = CW'(DIV - 1);
    localparam logic [BW-1:0]  BOUNCE_LAST = BW'(BOUNCE_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE_DN,
        HOLD,
        BOUNCE_UP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   divCnt_q;
    logic [CW-1:0]   divCnt_d;
    logic [BW-1:0]   bcnt_q;
    logic [BW-1:0]   bcnt_d;
    logic [7:0]      hcnt_q;
    logic [7:0]      hcnt_d;
    logic [7:0]      holdLen_q;
    logic            button_q;
    logic            busy_q;
    logic            done_q;
    logic            tick;
    logic            bounceBit;

    // The tick generator only runs while an event is in progress; IDLE pins the count at 0.
    assign tick     = (state_q != IDLE) && (divCnt_q == DIV_LAST);
    assign divCnt_d = tick ? '0 : divCnt_q + CW'(1);
    assign bcnt_d   = bcnt_q + BW'(1);
    assign hcnt_d   = hcnt_q + 8'd1;

`ifdef BOUNCE_GEN_NOISE_EN
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11; the bounce bit is the freshly shifted-in bit.
    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign bounceBit = lfsr_d[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED_EFF;
        end else if (tick) begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign bounceBit = ~button_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            divCnt_q  <= '0;
            bcnt_q    <= '0;
            hcnt_q    <= '0;
            holdLen_q <= '0;
            button_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    divCnt_q <= '0;
                    bcnt_q   <= '0;
                    hcnt_q   <= '0;
                    button_q <= 1'b0;
                    // A press coinciding with done is dropped so events never overlap.
                    if (press && !done_q) begin
                        holdLen_q <= (hold_ticks == 8'd0) ? 8'd1 : hold_ticks;
                        button_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= BOUNCE_DN;
                    end
                end

                BOUNCE_DN: begin
                    divCnt_q <= divCnt_d;
                    if (tick) begin
                        if (bcnt_d == BOUNCE_LAST) begin
                            bcnt_q   <= '0;
                            hcnt_q   <= '0;
                            button_q <= 1'b1;
                            state_q  <= HOLD;
                        end else begin
                            bcnt_q   <= bcnt_d;
                            button_q <= bounceBit;
                        end
                    end
                end

                HOLD: begin
                    divCnt_q <= divCnt_d;
                    if (tick) begin
                        if (hcnt_d == holdLen_q) begin
                            hcnt_q   <= '0;
                            bcnt_q   <= '0;
                            button_q <= 1'b0;
                            state_q  <= BOUNCE_UP;
                        end else begin
                            hcnt_q <= hcnt_d;
                        end
                    end
                end

                BOUNCE_UP: begin
                    divCnt_q <= divCnt_d;
                    if (tick) begin
                        if (bcnt_d == BOUNCE_LAST) begin
                            bcnt_q   <= '0;
                            button_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            bcnt_q   <= bcnt_d;
                            button_q <= bounceBit;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign button = button_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Directed bench for button_bounce_gen: fixed traces with DIV=4, bounce lengths 4 and 1, and reset abort.
// With BOUNCE_GEN_NOISE_EN defined, bounce windows are checked for reproducibility instead of exact values.
module tb_button_bounce_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       press1;
    logic       press2;
    logic [7:0] hold1;
    logic [7:0] hold2;
    logic       button1, busy1, done1;
    logic       button2, busy2, done2;

    int checks = 0;
    int errors = 0;

    logic traceCur   [1:50];
    logic traceFirst [1:50];

    button_bounce_gen #(.DIV(4), .BOUNCE_TICKS(4), .SEED(16'hACE1)) dut1 (
        .clk(clk), .reset(reset), .press(press1), .hold_ticks(hold1),
        .button(button1), .busy(busy1), .done(done1)
    );

    button_bounce_gen #(.DIV(4), .BOUNCE_TICKS(1), .SEED(16'hACE1)) dut2 (
        .clk(clk), .reset(reset), .press(press2), .hold_ticks(hold2),
        .button(button2), .busy(busy2), .done(done2)
    );

`ifdef BOUNCE_GEN_NOISE_EN
    logic press3;
    logic button3, busy3, done3;
    logic button4, busy4, done4;

    button_bounce_gen #(.DIV(4), .BOUNCE_TICKS(4), .SEED(16'h0000)) dut3 (
        .clk(clk), .reset(reset), .press(press3), .hold_ticks(8'd3),
        .button(button3), .busy(busy3), .done(done3)
    );

    button_bounce_gen #(.DIV(4), .BOUNCE_TICKS(4), .SEED(16'h0001)) dut4 (
        .clk(clk), .reset(reset), .press(press3), .hold_ticks(8'd3),
        .button(button4), .busy(busy4), .done(done4)
    );
`endif

    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hand-derived button trace for DIV=4, BOUNCE_TICKS=4, hold=3 with toggle bounce.
    function automatic logic expButton1(input int n);
        if (n >= 1  && n <= 4)  return 1'b1;
        if (n >= 9  && n <= 12) return 1'b1;
        if (n >= 17 && n <= 28) return 1'b1;
        if (n >= 33 && n <= 36) return 1'b1;
        if (n >= 41 && n <= 44) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit inBounce(input int n);
        return ((n >= 5 && n <= 16) || (n >= 33 && n <= 44));
    endfunction

    task automatic applyStimulus(input bit strayPresses, input string name);
        int doneCount;
        doneCount = 0;
        press1 = 1'b1;
        hold1  = 8'd3;
        nextCycle();
        press1 = 1'b0;
        hold1  = 8'd7;
        for (int n = 1; n <= 50; n++) begin
            traceCur[n] = button1;
`ifdef BOUNCE_GEN_NOISE_EN
            if (!inBounce(n))
                checkOutput($sformatf("%s button c%0d", name, n), 32'(button1), 32'(expButton1(n)));
`else
            checkOutput($sformatf("%s button c%0d", name, n), 32'(button1), 32'(expButton1(n)));
`endif
            checkOutput($sformatf("%s busy c%0d", name, n), 32'(busy1), 32'(n >= 1 && n <= 44));
            checkOutput($sformatf("%s done c%0d", name, n), 32'(done1), 32'(n == 45));
            if (done1 === 1'b1) doneCount++;
            if (strayPresses && (n == 10 || n == 44 || n == 45)) press1 = 1'b1;
            nextCycle();
            press1 = 1'b0;
        end
        checkOutput($sformatf("%s done count", name), 32'(doneCount), 32'd1);
    endtask

    initial begin
        int doneCount;
        reset  = 1'b0;
        press1 = 1'b0;
        press2 = 1'b0;
        hold1  = 8'd3;
        hold2  = 8'd0;
`ifdef BOUNCE_GEN_NOISE_EN
        press3 = 1'b0;
`endif
        nextCycle();
        nextCycle();
        checkOutput("reset button", 32'(button1), 32'd0);
        checkOutput("reset busy",   32'(busy1),   32'd0);
        checkOutput("reset done",   32'(done1),   32'd0);
        reset = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("idle button", 32'(button1), 32'd0);

        $display("[TB] scenario 1: hold 3 with ignored presses at 10, 44, 45");
        applyStimulus(1'b1, "s1");
        for (int n = 1; n <= 50; n++) traceFirst[n] = traceCur[n];

        $display("[TB] scenario 3: hold 0, single-tick bounce");
        press2 = 1'b1;
        hold2  = 8'd0;
        nextCycle();
        press2 = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            checkOutput($sformatf("s3 button c%0d", n), 32'(button2), 32'(n >= 1 && n <= 8));
            checkOutput($sformatf("s3 busy c%0d", n),   32'(busy2),   32'(n >= 1 && n <= 12));
            checkOutput($sformatf("s3 done c%0d", n),   32'(done2),   32'(n == 13));
            nextCycle();
        end

        $display("[TB] scenario 4: reset at cycle 20, then replay");
        press1 = 1'b1;
        hold1  = 8'd3;
        nextCycle();
        press1 = 1'b0;
        for (int n = 1; n < 20; n++) nextCycle();
        checkOutput("abort pre button", 32'(button1), 32'd1);
        checkOutput("abort pre busy",   32'(busy1),   32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abort button", 32'(button1), 32'd0);
        checkOutput("abort busy",   32'(busy1),   32'd0);
        checkOutput("abort done",   32'(done1),   32'd0);
        nextCycle();
        nextCycle();
        reset = 1'b1;
        doneCount = 0;
        for (int n = 0; n < 40; n++) begin
            if (done1 !== 1'b0) doneCount++;
            nextCycle();
        end
        checkOutput("abort no done", 32'(doneCount), 32'd0);
        checkOutput("abort idle button", 32'(button1), 32'd0);
        applyStimulus(1'b0, "replay");
        for (int n = 1; n <= 50; n++)
            checkOutput($sformatf("replay match c%0d", n), 32'(traceCur[n]), 32'(traceFirst[n]));

`ifdef BOUNCE_GEN_NOISE_EN
        $display("[TB] noise: SEED 0 against SEED 1");
        press3 = 1'b1;
        nextCycle();
        press3 = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            checkOutput($sformatf("seed0 button c%0d", n), 32'(button3), 32'(button4));
            checkOutput($sformatf("seed0 done c%0d", n),   32'(done3),   32'(n == 45));
            nextCycle();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
